// File: rtl/sr_pkg.sv
// sr_pkg: shared mode encodings, FSM states and ShiftRows row offsets
package sr_pkg;
  localparam logic [1:0] SR_BYPASS = 2'b00;
  localparam logic [1:0] SR_FWD    = 2'b01;
  localparam logic [1:0] SR_INV    = 2'b10;

  typedef enum logic {IDLE, STREAM} sr_state_e;

  // Row r shifts by r columns, except the wide NB=8 state where rows 2 and 3 shift one further
  function automatic int sr_offset(int nb, int row);
    return (nb == 8 && row >= 2) ? row + 1 : row;
  endfunction
endpackage

// File: rtl/sr_col_sel.sv
// sr_col_sel: picks one ShiftRows output column out of the full registered state
module sr_col_sel
  import sr_pkg::*;
#(
  parameter int NB = 4,
  localparam int IW = $clog2(NB)
) (
  input  logic [32*NB-1:0] state_i,
  input  logic [1:0]       mode_i,
  input  logic [IW-1:0]    idx_i,
  output logic [31:0]      col_o
);
  // Source column of row r for output column j; modes other than forward/inverse pass straight through
  function automatic int src_col(int j, int r, logic [1:0] m);
    int off = sr_offset(NB, r);
    return m == SR_FWD ? (j + off) % NB : m == SR_INV ? (j + NB - off) % NB : j;
  endfunction

  // Compare-and-select per row keeps every state slice at a constant position
  always_comb begin
    col_o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < NB; c++)
        if (c == src_col(int'(idx_i), r, mode_i)) col_o[31-8*r -: 8] = state_i[32*NB-1-8*(4*c+r) -: 8];
  end
endmodule

// File: rtl/sr_stream.sv
// sr_stream: accepts a whole state and streams its ShiftRows columns one per handshake
module sr_stream
  import sr_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*NB-1:0]      in_data,
  input  logic [1:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_col,
  output logic [$clog2(NB)-1:0] out_idx,
  output logic                  out_last
);
  localparam int IW = $clog2(NB);

  generate
    if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
      $error("sr_stream: NB must be 4, 6 or 8");
    end
  endgenerate

  sr_state_e         state_q, state_d;
  logic [32*NB-1:0]  data_q, data_d;
  logic [1:0]        mode_q, mode_d;
  logic [IW-1:0]     idx_q, idx_d;

  // Handshake outputs and next state; a final-beat accept reloads without a bubble
  always_comb begin
    out_valid = state_q == STREAM;
    out_last  = out_valid && idx_q == IW'(NB - 1);
    in_ready  = !out_valid || (out_last && out_ready);
    state_d   = state_q;
    data_d    = data_q;
    mode_d    = mode_q;
    idx_d     = idx_q;
    if (in_valid && in_ready) begin
      state_d = STREAM;
      data_d  = in_data;
      mode_d  = in_mode;
      idx_d   = '0;
    end else if (out_valid && out_ready) begin
      state_d = out_last ? IDLE : STREAM;
      idx_d   = out_last ? '0 : idx_q + IW'(1);
    end
  end

  // State, captured block and column index; reset discards any stream in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      mode_q  <= SR_BYPASS;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
    end
  end

  assign out_idx = idx_q;

  sr_col_sel #(.NB(NB)) u_col_sel (
    .state_i (data_q),
    .mode_i  (mode_q),
    .idx_i   (idx_q),
    .col_o   (out_col)
  );
endmodule

// File: tb/tb_sr_stream.sv
// tb_sr_stream: table vectors, handshake corner cases and a randomized scoreboard for sr_stream
module tb_sr_stream;
  typedef logic [7:0] bytes_t [32];
  typedef struct {
    logic [1:0]        mode;
    logic [3:0][31:0]  exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  logic in_valid4, in_ready4, out_valid4, out_ready4, out_last4;
  logic [127:0] in_data4;
  logic [1:0] in_mode4, out_idx4;
  logic [31:0] out_col4;
  logic in_valid8, in_ready8, out_valid8, out_ready8, out_last8;
  logic [255:0] in_data8;
  logic [1:0] in_mode8;
  logic [2:0] out_idx8;
  logic [31:0] out_col8;

  int tests = 0;
  int fails = 0;
  vec_t vt [4];
  bytes_t inc, rb;
  logic [31:0] qcol [$];
  int qidx [$];

  always #5 clk = ~clk;

  sr_stream #(.NB(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data4), .in_mode(in_mode4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_col(out_col4), .out_idx(out_idx4), .out_last(out_last4)
  );

  sr_stream #(.NB(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data8), .in_mode(in_mode8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_col(out_col8), .out_idx(out_idx8), .out_last(out_last8)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Row r of output column j comes from column j+C_r (forward), j-C_r (inverse) or j (otherwise)
  function automatic logic [31:0] model(bytes_t b, int nb, int mode, int j);
    logic [31:0] col;
    int off, src;
    col = '0;
    for (int r = 0; r < 4; r++) begin
      off = (nb == 8) ? (r < 2 ? r : r + 1) : r;
      src = mode == 1 ? (j + off) % nb : mode == 2 ? (j - off + nb) % nb : j;
      col[31-8*r -: 8] = b[4*src+r];
    end
    return col;
  endfunction

  function automatic logic [127:0] pack4(bytes_t b);
    logic [127:0] d;
    for (int k = 0; k < 16; k++) d[127-8*k -: 8] = b[k];
    return d;
  endfunction

  function automatic logic [255:0] pack8(bytes_t b);
    logic [255:0] d;
    for (int k = 0; k < 32; k++) d[255-8*k -: 8] = b[k];
    return d;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{2'b01, {32'h0c01060b, 32'h080d0207, 32'h04090e03, 32'h00050a0f}};
    vt[1] = '{2'b10, {32'h0c090603, 32'h0805020f, 32'h04010e0b, 32'h000d0a07}};
    vt[2] = '{2'b00, {32'h0c0d0e0f, 32'h08090a0b, 32'h04050607, 32'h00010203}};
    vt[3] = '{2'b11, {32'h0c0d0e0f, 32'h08090a0b, 32'h04050607, 32'h00010203}};
    for (int k = 0; k < 32; k++) inc[k] = 8'(k);
    reset_n = 1'b0;
    in_valid4 = 0; out_ready4 = 0; in_data4 = '0; in_mode4 = '0;
    in_valid8 = 0; out_ready8 = 1; in_data8 = '0; in_mode8 = '0;
    #2;
    chk("rst_out_valid", 32'(out_valid4), 0);
    chk("rst_out_col", out_col4, 0);
    chk("rst_out_idx", 32'(out_idx4), 0);
    chk("rst_out_last", 32'(out_last4), 0);
    chk("rst_in_ready", 32'(in_ready4), 1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    step();

    for (int v = 0; v < 4; v++) begin
      in_data4 = pack4(inc); in_mode4 = vt[v].mode; in_valid4 = 1; out_ready4 = 1;
      step();
      in_valid4 = 0; in_data4 = {$urandom, $urandom, $urandom, $urandom}; in_mode4 = 2'($urandom);
      for (int j = 0; j < 4; j++) begin
        chk("vec_valid", 32'(out_valid4), 1);
        chk("vec_col", out_col4, vt[v].exp[j]);
        chk("vec_idx", 32'(out_idx4), 32'(j));
        chk("vec_last", 32'(out_last4), 32'(j == 3));
        step();
      end
      chk("vec_done_valid", 32'(out_valid4), 0);
    end

    in_data4 = pack4(inc); in_mode4 = 2'b01; in_valid4 = 1; out_ready4 = 1;
    step();
    in_valid4 = 0;
    chk("stall_col0", out_col4, 32'h00050a0f);
    step();
    out_ready4 = 0;
    for (int s = 0; s < 3; s++) begin
      chk("stall_hold_col", out_col4, 32'h04090e03);
      chk("stall_hold_idx", 32'(out_idx4), 1);
      chk("stall_hold_valid", 32'(out_valid4), 1);
      step();
    end
    out_ready4 = 1;
    chk("stall_resume_col1", out_col4, 32'h04090e03);
    step();
    chk("stall_resume_col2", out_col4, 32'h080d0207);
    chk("stall_resume_idx2", 32'(out_idx4), 2);
    step();
    chk("stall_resume_col3", out_col4, 32'h0c01060b);
    step();
    chk("stall_done_valid", 32'(out_valid4), 0);

    for (int k = 0; k < 16; k++) rb[k] = 8'($urandom_range(0, 255));
    in_data4 = pack4(inc); in_mode4 = 2'b01; in_valid4 = 1; out_ready4 = 1;
    step();
    in_valid4 = 0;
    repeat (3) step();
    chk("b2b_last", 32'(out_last4), 1);
    in_data4 = pack4(rb); in_mode4 = 2'b10; in_valid4 = 1;
    #1;
    chk("b2b_in_ready", 32'(in_ready4), 1);
    step();
    in_valid4 = 0;
    for (int j = 0; j < 4; j++) begin
      chk("b2b_valid", 32'(out_valid4), 1);
      chk("b2b_idx", 32'(out_idx4), 32'(j));
      chk("b2b_col", out_col4, model(rb, 4, 2, j));
      step();
    end
    chk("b2b_done_valid", 32'(out_valid4), 0);

    in_data4 = pack4(inc); in_mode4 = 2'b01; in_valid4 = 1; out_ready4 = 1;
    step();
    in_valid4 = 0;
    step(); step();
    chk("mid_idx_before_reset", 32'(out_idx4), 2);
    reset_n = 0;
    #1;
    chk("mid_rst_valid", 32'(out_valid4), 0);
    chk("mid_rst_col", out_col4, 0);
    chk("mid_rst_idx", 32'(out_idx4), 0);
    @(posedge clk);
    #1 reset_n = 1;
    #1;
    chk("mid_rel_in_ready", 32'(in_ready4), 1);
    for (int s = 0; s < 3; s++) begin
      step();
      chk("mid_rel_no_stale", 32'(out_valid4), 0);
    end

    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int k = 0; k < 16; k++) rb[k] = 8'($urandom_range(0, 255));
      in_valid4 = ($urandom_range(0, 1) == 1);
      in_data4 = pack4(rb);
      in_mode4 = 2'($urandom);
      out_ready4 = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_valid", 32'(out_valid4), 32'(qcol.size() > 0));
      chk("rnd_in_ready", 32'(in_ready4), 32'(qcol.size() == 0 || (qcol.size() == 1 && out_ready4)));
      if (out_valid4 && out_ready4 && qcol.size() > 0) begin
        chk("rnd_col", out_col4, qcol.pop_front());
        chk("rnd_idx", 32'(out_idx4), 32'(qidx.pop_front()));
      end
      if (in_valid4 && in_ready4)
        for (int j = 0; j < 4; j++) begin
          qcol.push_back(model(rb, 4, int'(in_mode4), j));
          qidx.push_back(j);
        end
      step();
    end
    in_valid4 = 0;

    in_data8 = pack8(inc); in_mode8 = 2'b01; in_valid8 = 1;
    step();
    in_valid8 = 0;
    chk("nb8_fwd_col0", out_col8, 32'h00050e13);
    for (int j = 0; j < 8; j++) begin
      chk("nb8_fwd_col", out_col8, model(inc, 8, 1, j));
      chk("nb8_fwd_last", 32'(out_last8), 32'(j == 7));
      step();
    end
    for (int k = 0; k < 32; k++) rb[k] = 8'($urandom_range(0, 255));
    in_data8 = pack8(rb); in_mode8 = 2'b10; in_valid8 = 1;
    step();
    in_valid8 = 0;
    for (int j = 0; j < 8; j++) begin
      chk("nb8_inv_col", out_col8, model(rb, 8, 2, j));
      step();
    end
    chk("nb8_done_valid", 32'(out_valid8), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
